// File: rtl/rtc_bus_arbiter.sv
// Arbitrates a write requester and a read requester onto a multiplexed RTC address/data bus.
// Define RTC_ARB_FAIR_EN for round-robin tie-breaking; otherwise a write wins every tie.
module rtc_bus_arbiter #(
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       CSO,
  output logic       WRO,
  output logic       RDO,
  output logic       ADO,
  output logic       busy
);

  localparam int unsigned MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant, grant_wr;
  logic             is_wr;
  logic [7:0]       addr_q, data_q, rd_shadow;
  logic             cso_c, wro_c, rdo_c, ado_c, oe_c, wr_ack_c, rd_valid_c;
  logic [7:0]       bus_c;

`ifdef RTC_ARB_FAIR_EN
  logic last_rd;

  // Round-robin memory: which requester won the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)      last_rd <= 1'b1;
    else if (grant) last_rd <= ~grant_wr;
  end

  assign grant_wr = wr_req && (!rd_req || last_rd);
`else
  assign grant_wr = wr_req;
`endif

  // Next-state and phase counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT_W'(cnt + 1'b1);
    grant     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (wr_req || rd_req) begin
          grant     = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: if (cnt == PH_LAST) begin
        cnt_nxt   = '0;
        state_nxt = (GAP_CYC == 0) ? DATA : GAP1;
      end
      GAP1: if (cnt == GAP_LAST) begin
        cnt_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: if (cnt == PH_LAST) begin
        cnt_nxt   = '0;
        state_nxt = (GAP_CYC == 0) ? DONE : GAP2;
      end
      GAP2: if (cnt == GAP_LAST) begin
        cnt_nxt   = '0;
        state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus strobes for the current phase; registered one cycle later.
  always_comb begin
    cso_c      = 1'b1;
    wro_c      = 1'b1;
    rdo_c      = 1'b1;
    ado_c      = 1'b1;
    oe_c       = 1'b0;
    bus_c      = 8'h00;
    wr_ack_c   = 1'b0;
    rd_valid_c = 1'b0;
    case (state)
      ADDR: begin
        cso_c = 1'b0;
        wro_c = 1'b0;
        ado_c = 1'b0;
        oe_c  = 1'b1;
        bus_c = addr_q;
      end
      DATA: begin
        cso_c = 1'b0;
        if (is_wr) begin
          wro_c = 1'b0;
          oe_c  = 1'b1;
          bus_c = data_q;
        end else begin
          rdo_c = 1'b0;
        end
      end
      DONE: begin
        wr_ack_c   = is_wr;
        rd_valid_c = ~is_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      rd_shadow <= 8'h00;
      rd_data   <= 8'h00;
      CSO       <= 1'b1;
      WRO       <= 1'b1;
      RDO       <= 1'b1;
      ADO       <= 1'b1;
      bus_oe    <= 1'b0;
      bus_out   <= 8'h00;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        is_wr  <= grant_wr;
        addr_q <= grant_wr ? wr_addr : rd_addr;
        data_q <= wr_data;
      end
      // The last edge seen with RDO low closes the read data phase.
      if (!RDO) rd_shadow <= bus_in;
      if (rd_valid_c) rd_data <= RDO ? rd_shadow : bus_in;
      CSO      <= cso_c;
      WRO      <= wro_c;
      RDO      <= rdo_c;
      ADO      <= ado_c;
      bus_oe   <= oe_c;
      bus_out  <= bus_c;
      wr_ack   <= wr_ack_c;
      rd_valid <= rd_valid_c;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: two instances (default timing and PHASE_CYC=1/GAP_CYC=0)
// checked against a timeline reference model and an ack scoreboard.
module tb_rtc_bus_arbiter;

  localparam int N = 2;
`ifdef RTC_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  function automatic int ph(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  typedef struct {
    bit is_wr;
    int ack_cyc;
  } exp_t;

  logic         clk;
  logic [N-1:0] reset, wr_req, rd_req, wr_ack, rd_valid, bus_oe;
  logic [N-1:0] cso, wro, rdo, ado, busy;
  logic [7:0]   wr_addr [N];
  logic [7:0]   wr_data [N];
  logic [7:0]   rd_addr [N];
  logic [7:0]   rd_data [N];
  logic [7:0]   bus_out [N];
  logic [7:0]   bus_in  [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t       sb [N][$];
  bit         act [N];
  int         g [N];
  bit         m_wr [N];
  bit         last_rd [N];
  logic [7:0] m_addr [N];
  logic [7:0] m_data [N];
  logic [7:0] cap [N];
  logic [7:0] exp_rd [N];
  logic [5:0] exp_vec [N];
  logic [7:0] exp_bus [N];
  bit         exp_bus_chk [N];

  bit keep_wr, keep_rd, force_bin;

  rtc_bus_arbiter #(.PHASE_CYC(4), .GAP_CYC(2)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]),
    .CSO(cso[0]), .WRO(wro[0]), .RDO(rdo[0]), .ADO(ado[0]), .busy(busy[0])
  );

  rtc_bus_arbiter #(.PHASE_CYC(1), .GAP_CYC(0)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]),
    .CSO(cso[1]), .WRO(wro[1]), .RDO(rdo[1]), .ADO(ado[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a transaction is a timeline of offsets from its grant edge.
  task automatic model_step(input int d);
    int  len, k, p, q;
    bit  gw, b;
    p   = ph(d);
    q   = gp(d);
    len = 2*p + 2*q + 1;
    if (reset[d]) begin
      if (act[d] && (cyc - g[d]) <= len && sb[d].size() > 0) sb[d].delete(sb[d].size() - 1);
      act[d]         = 1'b0;
      last_rd[d]     = 1'b1;
      exp_rd[d]      = 8'h00;
      cap[d]         = 8'h00;
      exp_vec[d]     = 6'b111100;
      exp_bus[d]     = 8'h00;
      exp_bus_chk[d] = 1'b1;
      return;
    end
    if (act[d] && (cyc - g[d]) > len) act[d] = 1'b0;
    if (!act[d] && (wr_req[d] || rd_req[d])) begin
      gw         = wr_req[d] && (!rd_req[d] || !FAIR || last_rd[d]);
      last_rd[d] = !gw;
      act[d]     = 1'b1;
      g[d]       = cyc;
      m_wr[d]    = gw;
      m_addr[d]  = gw ? wr_addr[d] : rd_addr[d];
      m_data[d]  = wr_data[d];
      sb[d].push_back('{is_wr: gw, ack_cyc: cyc + len});
    end
    k = act[d] ? (cyc - g[d]) : -1;
    b = act[d] && (k < len);
    exp_vec[d]     = {5'b11110, b};
    exp_bus_chk[d] = 1'b0;
    if (act[d] && k >= 1 && k <= p) begin
      exp_vec[d]     = {5'b00101, b};
      exp_bus[d]     = m_addr[d];
      exp_bus_chk[d] = 1'b1;
    end else if (act[d] && k >= p + q + 1 && k <= 2*p + q) begin
      if (m_wr[d]) begin
        exp_vec[d]     = {5'b00111, b};
        exp_bus[d]     = m_data[d];
        exp_bus_chk[d] = 1'b1;
      end else begin
        exp_vec[d] = {5'b01010, b};
      end
    end
    if (act[d] && !m_wr[d] && k == 2*p + q + 1) cap[d] = bus_in[d];
    if (act[d] && !m_wr[d] && k == len) exp_rd[d] = cap[d];
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < N; d++) model_step(d);
  end

  task automatic check_step(input int d);
    exp_t e;
    checks++;
    if ({cso[d], wro[d], rdo[d], ado[d], bus_oe[d], busy[d]} !== exp_vec[d]) begin
      errors++;
      $display("FAIL strobes dut%0d cyc %0d: got CSO/WRO/RDO/ADO/OE/BUSY=%b expected %b",
               d, cyc, {cso[d], wro[d], rdo[d], ado[d], bus_oe[d], busy[d]}, exp_vec[d]);
    end
    if (exp_bus_chk[d]) begin
      checks++;
      if (bus_out[d] !== exp_bus[d]) begin
        errors++;
        $display("FAIL bus_out dut%0d cyc %0d: got %h expected %h", d, cyc, bus_out[d], exp_bus[d]);
      end
    end
    checks++;
    if (rd_data[d] !== exp_rd[d]) begin
      errors++;
      $display("FAIL rd_data dut%0d cyc %0d: got %h expected %h", d, cyc, rd_data[d], exp_rd[d]);
    end
    checks++;
    if ((!wro[d] && !rdo[d]) || (bus_oe[d] && !rdo[d])) begin
      errors++;
      $display("FAIL invariant dut%0d cyc %0d: got WRO=%b RDO=%b OE=%b expected no overlap",
               d, cyc, wro[d], rdo[d], bus_oe[d]);
    end
    if (wr_ack[d] || rd_valid[d]) begin
      checks++;
      if (wr_ack[d] && rd_valid[d]) begin
        errors++;
        $display("FAIL ack_both dut%0d cyc %0d: got wr_ack=1 rd_valid=1 expected one", d, cyc);
      end else if (sb[d].size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected dut%0d cyc %0d: got wr_ack=%b rd_valid=%b expected none",
                 d, cyc, wr_ack[d], rd_valid[d]);
      end else begin
        e = sb[d].pop_front();
        if (e.is_wr != wr_ack[d] || e.ack_cyc != cyc) begin
          errors++;
          $display("FAIL ack dut%0d: got wr=%b at cyc %0d expected wr=%b at cyc %0d",
                   d, wr_ack[d], cyc, e.is_wr, e.ack_cyc);
        end
      end
    end else if (sb[d].size() > 0 && sb[d][0].ack_cyc <= cyc) begin
      checks++;
      errors++;
      e = sb[d].pop_front();
      $display("FAIL ack_missing dut%0d cyc %0d: got no ack expected wr=%b at cyc %0d",
               d, cyc, e.is_wr, e.ack_cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) check_step(d);
  end

  // One negedge step: requesters drop on ack unless told to keep, bus_in refreshed.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      if (wr_ack[d] && !keep_wr) wr_req[d] = 1'b0;
      if (rd_valid[d] && !keep_rd) rd_req[d] = 1'b0;
      bus_in[d] = force_bin ? 8'h59 : 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && ((|wr_req) || (|rd_req)); i++) tick();
    checks++;
    if ((|wr_req) || (|rd_req)) begin
      errors++;
      $display("FAIL drain_timeout: got wr_req=%b rd_req=%b expected all served", wr_req, rd_req);
      wr_req = '0;
      rd_req = '0;
    end
  endtask

  initial begin
    reset     = '1;
    wr_req    = '0;
    rd_req    = '0;
    keep_wr   = 1'b0;
    keep_rd   = 1'b0;
    force_bin = 1'b0;
    for (int d = 0; d < N; d++) begin
      wr_addr[d] = 8'h00;
      wr_data[d] = 8'h00;
      rd_addr[d] = 8'h00;
      bus_in[d]  = 8'h00;
    end
    repeat (3) tick();
    reset = '0;
    tick();

    // Write 0x45 to 0x21; data changes to 0x99 once the address phase is over.
    for (int d = 0; d < N; d++) begin
      wr_req[d]  = 1'b1;
      wr_addr[d] = 8'h21;
      wr_data[d] = 8'h45;
    end
    repeat (6) tick();
    for (int d = 0; d < N; d++) wr_data[d] = 8'h99;
    wait_idle();

    // Read from 0x22 with the RTC returning 0x59.
    force_bin = 1'b1;
    for (int d = 0; d < N; d++) begin
      rd_req[d]  = 1'b1;
      rd_addr[d] = 8'h22;
    end
    wait_idle();
    force_bin = 1'b0;
    repeat (3) tick();

    // Both requesters held high: tie arbitration.
    keep_wr = 1'b1;
    keep_rd = 1'b1;
    wr_req  = '1;
    rd_req  = '1;
    repeat (60) tick();
    keep_wr = 1'b0;
    keep_rd = 1'b0;
    wait_idle();
    repeat (2) tick();

    // Reset during the data phase of a write; the held request restarts.
    for (int d = 0; d < N; d++) begin
      wr_req[d]  = 1'b1;
      wr_addr[d] = 8'h30;
      wr_data[d] = 8'hA5;
    end
    repeat (9) tick();
    reset = '1;
    tick();
    reset = '0;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < N; d++) begin
        if (!wr_req[d] && $urandom_range(3) == 0) begin
          wr_req[d]  = 1'b1;
          wr_addr[d] = 8'($urandom);
          wr_data[d] = 8'($urandom);
        end else if (wr_req[d] && $urandom_range(7) == 0) begin
          wr_addr[d] = 8'($urandom);
          wr_data[d] = 8'($urandom);
        end
        if (!rd_req[d] && $urandom_range(3) == 0) begin
          rd_req[d]  = 1'b1;
          rd_addr[d] = 8'($urandom);
        end else if (rd_req[d] && $urandom_range(7) == 0) begin
          rd_addr[d] = 8'($urandom);
        end
        reset[d] = ($urandom_range(150) == 0);
      end
      keep_wr = 1'($urandom_range(1));
      keep_rd = 1'($urandom_range(1));
      tick();
    end
    reset   = '0;
    keep_wr = 1'b0;
    keep_rd = 1'b0;
    wait_idle();
    repeat (20) tick();

    for (int d = 0; d < N; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL scoreboard_empty dut%0d: got %0d pending expected 0", d, sb[d].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter PHASE_CYC, default 4: clocks each strobe phase (address or data) is held active.
REQ-002 Parameter GAP_CYC, default 2: clocks all strobes are held inactive between phases and after the data phase.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_req  in  1  level write request; held by requester until wr_ack.
REQ-006 wr_addr  in  8  RTC register address for the write.
REQ-007 wr_data  in  8  data to write.
REQ-008 wr_ack  out  1  one-cycle pulse; write transaction complete.
REQ-009 rd_req  in  1  level read request; held by requester until rd_valid.
REQ-010 rd_addr  in  8  RTC register address for the read.
REQ-011 rd_data  out  8  last read result; held until the next read completes.
REQ-012 rd_valid  out  1  one-cycle pulse; rd_data updated this cycle.
REQ-013 bus_out  out  8  value driven onto the multiplexed bus.
REQ-014 bus_oe  out  1  1 = drive bus_out; 0 = release the bus (tristate at top level).
REQ-015 bus_in  in  8  value sampled from the multiplexed bus.
REQ-016 CSO, WRO, RDO, ADO  out  1 each  active-low chip-select, write, read, address/data strobes.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, GAP1, DATA, GAP2, DONE; IDLE->ADDR on grant, ADDR->GAP1, GAP1->DATA, DATA->GAP2 after their cycle counts, GAP2->DONE, DONE->IDLE after one cycle.
REQ-019 Grant occurs in IDLE on the edge where wr_req or rd_req is high; address, data and direction are latched at that edge, and later input changes are ignored until DONE.
REQ-020 ADDR (PHASE_CYC cycles): CSO=0, WRO=0, ADO=0, RDO=1, bus_oe=1, bus_out=latched address.
REQ-021 GAP1/GAP2 (GAP_CYC cycles each): CSO=WRO=RDO=ADO=1, bus_oe=0.
REQ-022 DATA write (PHASE_CYC cycles): CSO=0, WRO=0, ADO=1, RDO=1, bus_oe=1, bus_out=latched data.
REQ-023 DATA read (PHASE_CYC cycles): CSO=0, RDO=0, ADO=1, WRO=1, bus_oe=0; bus_in is sampled on the last DATA cycle.
REQ-024 DONE: assert wr_ack or rd_valid for exactly one cycle; on a read, rd_data is updated in the same cycle.
REQ-025 Latency: the ack/valid pulse is asserted 2*PHASE_CYC+2*GAP_CYC+1 cycles after the grant edge (13 with defaults).
REQ-026 A request still high in the cycle after its ack is treated as a new request.
REQ-027 Arbitration when both requests are high in IDLE is set by REQ-033/034; with only one request high, that request is granted.
REQ-028 WRO and RDO are never both 0, and bus_oe=1 never coincides with RDO=0.

Reset
REQ-029 On reset: state=IDLE, CSO=WRO=RDO=ADO=1, bus_oe=0, bus_out=0, rd_data=0, wr_ack=rd_valid=0, busy=0, last-grant=read.
REQ-030 Reset mid-transaction aborts it: outputs take reset values on the next edge, no ack/valid is issued, and the pending request is re-arbitrated after reset deasserts.

Configuration
REQ-031 Macro RTC_ARB_FAIR_EN selects the arbitration policy.
REQ-032 Only the tie case (both requests high in IDLE) is affected by the macro.
REQ-033 With RTC_ARB_FAIR_EN defined, a tie grants the requester not granted last (round-robin); last-grant updates at each grant.
REQ-034 Without RTC_ARB_FAIR_EN, a tie always grants the write (fixed priority) and the last-grant register is omitted.

Verification
REQ-035 Write wr_addr=0x21, wr_data=0x45, defaults -> bus_out=0x21 with ADO=0 for 4 cycles, 2 idle cycles, bus_out=0x45 with WRO=0 for 4 cycles, wr_ack 13 cycles after grant.
REQ-036 Read rd_addr=0x22, bus_in=0x59 during DATA -> RDO=0 for 4 cycles with bus_oe=0, rd_valid pulse, rd_data=0x59 held afterwards.
REQ-037 wr_req and rd_req both held high, RTC_ARB_FAIR_EN defined -> grants alternate W,R,W,R; undefined -> only writes are granted while wr_req stays high.
REQ-038 reset pulsed during DATA of a write -> next edge all strobes=1, bus_oe=0, no wr_ack; with wr_req still high, a full write restarts.
REQ-039 Change wr_data from 0x45 to 0x99 during GAP1 -> bus_out=0x45 in DATA (latched value).
REQ-040 PHASE_CYC=1, GAP_CYC=0 -> ack/valid 3 cycles after the grant edge; the strobe invariants of REQ-028 hold throughout.
